// File: rtl/regfile_wb_arb.sv
// regfile_wb_arb: shares the integer register file's single write port between
// three writeback requesters (0 = ALU, 1 = load unit, 2 = CSR/mul-div).
// A request is accepted over valid/ready and issued to the file one cycle later;
// the registered write doubles as the forwarding bus.
//
// Optional build macro: WB_ARB_RR_EN
//   undefined : fixed priority 0 > 1 > 2 with starvation promotion
//   defined   : round-robin priority driven by rr_ptr
//
// Writes to x0 are acknowledged immediately, never issued, and never compete.

module regfile_wb_arb #(
   parameter int unsigned STARVE_MAX = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  req_valid,
   input  logic [14:0] req_addr,
   input  logic [95:0] req_data,
   output logic [2:0]  req_ready,
   output logic        wr_en,
   output logic [4:0]  wr_addr,
   output logic [31:0] wr_data,
   output logic        fwd_valid,
   output logic [4:0]  fwd_addr,
   output logic [31:0] fwd_data,
   output logic [15:0] conflict_cnt
);

   logic [2:0]  live;
   logic [2:0]  zero_req;
   logic [2:0]  grant;
   logic        any_grant;
   logic        multi_live;
   logic [4:0]  sel_addr;
   logic [31:0] sel_data;

   // Split requests into live writes and x0 writes.
   always_comb begin
      live     = '0;
      zero_req = '0;
      for (int i = 0; i < 3; i++) begin
         live[i]     = req_valid[i] && (req_addr[5*i +: 5] != 5'd0);
         zero_req[i] = req_valid[i] && (req_addr[5*i +: 5] == 5'd0);
      end
   end

   assign multi_live = (live[0] & live[1]) | (live[0] & live[2]) | (live[1] & live[2]);

`ifdef WB_ARB_RR_EN

   logic [1:0] rr_ptr;

   // Round-robin pick: first live requester starting at rr_ptr.
   always_comb begin
      int idx;
      grant = '0;
      idx   = 0;
      for (int k = 0; k < 3; k++) begin
         idx = (int'(rr_ptr) + k) % 3;
         if ((grant == 3'b000) && live[idx]) begin
            grant[idx] = 1'b1;
         end
      end
   end

   // Pointer moves just past the last live grant and holds otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= 2'd0;
      end else begin
         case (grant)
            3'b001:  rr_ptr <= 2'd1;
            3'b010:  rr_ptr <= 2'd2;
            3'b100:  rr_ptr <= 2'd0;
            default: rr_ptr <= rr_ptr;
         endcase
      end
   end

`else

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [3:0] wait_q [3];
   logic [2:0] starved;

   // Starved requesters outrank everyone; ties and the normal case go lowest index first.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         starved[i] = live[i] && (wait_q[i] == STARVE_LIM);
      end
      grant = '0;
      if (starved != 3'b000) begin
         if (starved[0])      grant = 3'b001;
         else if (starved[1]) grant = 3'b010;
         else                 grant = 3'b100;
      end else begin
         if (live[0])         grant = 3'b001;
         else if (live[1])    grant = 3'b010;
         else if (live[2])    grant = 3'b100;
      end
   end

   // Per-requester wait counters: count blocked cycles, clear on grant or idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) wait_q[i] <= 4'd0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (!live[i] || grant[i]) begin
               wait_q[i] <= 4'd0;
            end else if (wait_q[i] != STARVE_LIM) begin
               wait_q[i] <= wait_q[i] + 4'd1;
            end
         end
      end
   end

`endif

   assign any_grant = |grant;

   // Mux the granted requester's address and data.
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < 3; i++) begin
         if (grant[i]) begin
            sel_addr = req_addr[5*i +: 5];
            sel_data = req_data[32*i +: 32];
         end
      end
   end

   // Nothing is accepted while reset is held.
   assign req_ready = rst ? 3'b000 : (zero_req | grant);

   // Register the granted write; address and data hold when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         wr_en <= any_grant;
         if (any_grant) begin
            wr_addr <= sel_addr;
            wr_data <= sel_data;
         end
      end
   end

   // Saturating count of cycles with two or more live requests.
   always_ff @(posedge clk) begin
      if (rst) begin
         conflict_cnt <= '0;
      end else if (multi_live && (conflict_cnt != 16'hFFFF)) begin
         conflict_cnt <= conflict_cnt + 16'd1;
      end
   end

   assign fwd_valid = wr_en;
   assign fwd_addr  = wr_addr;
   assign fwd_data  = wr_data;

endmodule
